counter_seq_ctrl: RTL and testbench
===================================

Name: counter_seq_ctrl

Overview:
Sequencing controller for the team's 4-bit up-counter datapath. It adds programmable start/stop/pause, a clock prescaler, a start value, a terminal limit, and a one-shot or auto-reload mode. The counter register is embedded, and the block emits a terminal-count pulse and status flags for the surrounding control logic.

Parameters:
- WIDTH, 4, count/load/limit width.
- PRESC_W, 4, prescaler divide-value width.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- res  in  1  asynchronous, active-low reset. res=0 clears all state immediately.
- start  in  1  pulse; latch config and (re)start counting.
- stop  in  1  pulse; abort to IDLE, count retained.
- pause  in  1  level; freeze while RUN.
- load_val  in  WIDTH  start/reload value; sampled on start.
- limit  in  WIDTH  terminal value; sampled on start.
- presc  in  PRESC_W  step every presc+1 cycles; sampled on start.
- auto_reload  in  1  1=reload and continue, 0=one-shot; sampled on start.
- count  out  WIDTH  current count (registered).
- busy  out  1  1 in RUN or HOLD.
- tc  out  1  one-cycle terminal-count pulse (registered).
- done  out  1  1 in DONE (one-shot finished).

Behaviour:
- Reset (res=0, async): state=IDLE, count=0, prescaler count=0, shadow config=0, busy=0, tc=0, done=0.
- States: IDLE, RUN, HOLD, DONE. Input priority, evaluated each edge: stop > start > pause.
- stop (any state): next state IDLE, count unchanged, prescaler cleared, tc=0.
- start (any state, stop=0):
  - Latch load_val/limit/presc/auto_reload into shadow registers.
  - count<=load_val, prescaler<=0, next state RUN.
  - Restart from RUN, HOLD or DONE is legal.
- RUN:
  - Prescaler increments each cycle. When prescaler==shadow presc, a step occurs and the prescaler returns to 0.
  - With presc=0 a step occurs every cycle.
- Step with count!=limit: count<=count+1 modulo 2^WIDTH. 15 wraps to 0, so limit<load_val is legal and wraps.
- Step with count==limit (terminal step): tc=1 on the following cycle (registered, exactly one cycle).
  - auto_reload=1: count<=shadow load_val, stay RUN.
  - auto_reload=0: count holds limit, next state DONE.
- Period: (limit-load_val mod 2^WIDTH)+1 steps, each presc+1 cycles.
- pause=1 in RUN: next state HOLD; count and prescaler frozen, no step that edge. pause=0 in HOLD: return to RUN, prescaler resumes from its frozen value.
- pause is ignored in IDLE and DONE.
- DONE: done=1, count holds. Only start or stop leave DONE.
- Timing: start sampled at edge E gives count=load_val and busy=1 after E. With presc=0, the first increment is visible after E+1.
- busy and done are decoded from the registered state. tc and done are never simultaneously high except in the first DONE cycle of one-shot mode (tc=1, done=1).
- start and stop in the same cycle: stop wins, shadow config not updated.
- Config input changes while running have no effect until the next start.
- res asserted mid-run: immediate return to reset values. First start after release behaves normally.

Decomposition:
- Shared package counter_pkg:
  - state enum type (IDLE=2'd0, RUN=2'd1, HOLD=2'd2, DONE=2'd3);
  - default WIDTH/PRESC_W constants.
- One natural sub-module: counter_core.
  - WIDTH-bit register with async active-low clear, synchronous load (load, d) and enable (en) increment; load has priority over en.
  - The controller owns the FSM, prescaler, shadow registers and tc/done generation, and drives counter_core's load/en.

Test Plan:
- Reset mid-run: RUN with count=9, drop res for 3 cycles -> count=0, busy=0, tc=0, done=0 immediately; stays IDLE after release until start.
- One-shot, no prescale: load_val=3, limit=6, presc=0, auto_reload=0, start -> count 3,4,5,6,6. tc=1 exactly one cycle, coincident with entry to DONE. done=1 and count=6 held until next start.
- Auto-reload with prescale and wrap: load_val=14, limit=1, presc=2, auto_reload=1 -> count 14,15,0,1, each held 3 cycles, then back to 14. tc pulses once per 12 cycles; busy stays 1.
- Pause: RUN with presc=3, assert pause for 5 cycles mid-prescale -> count and prescaler frozen, busy=1. On release, the step arrives after the remaining prescale cycles only.
- Stop vs start collision: assert start and stop together while count=5 in RUN -> IDLE, count=5, busy=0, config unchanged. Following start alone reloads load_val.
- Restart from DONE with new config: after one-shot done, start with load_val=0, limit=2 -> done drops next cycle, count 0,1,2, tc pulse, DONE again.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and defaults for the up-counter sequencing controller.
// Imported by the controller and its counter core.
package counter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int CNT_WIDTH   = 4;
   localparam int CNT_PRESC_W = 4;

endpackage

// File: rtl/counter_core.sv
// WIDTH-bit up-counter register with synchronous load and enable.
// Load takes priority over the increment enable.
module counter_core
   import counter_pkg::*;
#(
   parameter int WIDTH = CNT_WIDTH
) (
   input  logic             clock,
   input  logic             res,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             en,
   output logic [WIDTH-1:0] q
);

   // count register: load wins, otherwise wrap-around increment
   always_ff @(posedge clock or negedge res) begin
      if (!res) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end else if (en) begin
         q <= q + 1'b1;
      end
   end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller: start/stop/pause, prescaler, limit and reload
// around an embedded counter_core; emits a registered terminal pulse.
module counter_seq_ctrl
   import counter_pkg::*;
#(
   parameter int WIDTH   = CNT_WIDTH,
   parameter int PRESC_W = CNT_PRESC_W
) (
   input  logic               clock,
   input  logic               res,
   input  logic               start,
   input  logic               stop,
   input  logic               pause,
   input  logic [WIDTH-1:0]   load_val,
   input  logic [WIDTH-1:0]   limit,
   input  logic [PRESC_W-1:0] presc,
   input  logic               auto_reload,
   output logic [WIDTH-1:0]   count,
   output logic               busy,
   output logic               tc,
   output logic               done
);

   state_t               state_q;
   state_t               state_d;
   logic [PRESC_W-1:0]   pcnt_q;
   logic [PRESC_W-1:0]   pcnt_d;
   logic [WIDTH-1:0]     sh_load;
   logic [WIDTH-1:0]     sh_limit;
   logic [PRESC_W-1:0]   sh_presc;
   logic                 sh_auto;
   logic                 latch;
   logic                 tc_q;
   logic                 tc_d;
   logic                 core_load;
   logic                 core_en;
   logic [WIDTH-1:0]     core_d;

   counter_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clock (clock),
      .res   (res),
      .load  (core_load),
      .d     (core_d),
      .en    (core_en),
      .q     (count)
   );

   // state, prescaler, shadow config and terminal pulse registers
   always_ff @(posedge clock or negedge res) begin
      if (!res) begin
         state_q  <= IDLE;
         pcnt_q   <= '0;
         sh_load  <= '0;
         sh_limit <= '0;
         sh_presc <= '0;
         sh_auto  <= 1'b0;
         tc_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         pcnt_q  <= pcnt_d;
         tc_q    <= tc_d;
         if (latch) begin
            sh_load  <= load_val;
            sh_limit <= limit;
            sh_presc <= presc;
            sh_auto  <= auto_reload;
         end
      end
   end

   // next state, prescaler step and counter-core control
   // a HOLD edge with pause released already advances like RUN, so the
   // step lands after exactly the prescale cycles left before the pause
   always_comb begin
      state_d   = state_q;
      pcnt_d    = pcnt_q;
      latch     = 1'b0;
      tc_d      = 1'b0;
      core_load = 1'b0;
      core_en   = 1'b0;
      core_d    = sh_load;
      if (stop) begin
         state_d = IDLE;
         pcnt_d  = '0;
      end else if (start) begin
         state_d   = RUN;
         pcnt_d    = '0;
         latch     = 1'b1;
         core_load = 1'b1;
         core_d    = load_val;
      end else begin
         case (state_q)
            RUN, HOLD: begin
               if (pause) begin
                  state_d = HOLD;
               end else begin
                  state_d = RUN;
                  if (pcnt_q == sh_presc) begin
                     pcnt_d = '0;
                     if (count == sh_limit) begin
                        tc_d = 1'b1;
                        if (sh_auto) begin
                           core_load = 1'b1;
                        end else begin
                           state_d = DONE;
                        end
                     end else begin
                        core_en = 1'b1;
                     end
                  end else begin
                     pcnt_d = pcnt_q + 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // status decode from the registered state
   always_comb begin
      busy = (state_q == RUN) || (state_q == HOLD);
      done = (state_q == DONE);
      tc   = tc_q;
   end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl: vector table plus
// hand-written pause and asynchronous reset sequences.
module tb_counter_seq_ctrl;

   logic       clock = 1'b0;
   logic       res;
   logic       start;
   logic       stop;
   logic       pause;
   logic [3:0] load_val;
   logic [3:0] limit;
   logic [3:0] presc;
   logic       auto_reload;
   logic [3:0] count;
   logic       busy;
   logic       tc;
   logic       done;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic       st;
      logic       sp;
      logic       pa;
      logic [3:0] lv;
      logic [3:0] lim;
      logic [3:0] pr;
      logic       ar;
      logic [3:0] ec;
      logic       eb;
      logic       et;
      logic       ed;
   } vec_t;

   vec_t vq[$];

   counter_seq_ctrl #(
      .WIDTH   (4),
      .PRESC_W (4)
   ) dut (
      .clock       (clock),
      .res         (res),
      .start       (start),
      .stop        (stop),
      .pause       (pause),
      .load_val    (load_val),
      .limit       (limit),
      .presc       (presc),
      .auto_reload (auto_reload),
      .count       (count),
      .busy        (busy),
      .tc          (tc),
      .done        (done)
   );

   // free-running clock
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string nm, input int c, input int b,
                          input int t, input int d);
      chk({nm, "_count"}, int'(count), c);
      chk({nm, "_busy"}, int'(busy), b);
      chk({nm, "_tc"}, int'(tc), t);
      chk({nm, "_done"}, int'(done), d);
   endtask

   function automatic void add(
      input logic st, input logic sp, input logic pa,
      input logic [3:0] lv, input logic [3:0] lim,
      input logic [3:0] pr, input logic ar,
      input logic [3:0] ec, input logic eb,
      input logic et, input logic ed);
      vec_t v;
      v.st = st; v.sp = sp; v.pa = pa;
      v.lv = lv; v.lim = lim; v.pr = pr; v.ar = ar;
      v.ec = ec; v.eb = eb; v.et = et; v.ed = ed;
      vq.push_back(v);
   endfunction

   task automatic drive(input logic st, input logic sp,
                        input logic pa, input logic [3:0] lv,
                        input logic [3:0] lim, input logic [3:0] pr,
                        input logic ar);
      start = st; stop = sp; pause = pa;
      load_val = lv; limit = lim; presc = pr; auto_reload = ar;
   endtask

   initial begin
      logic [3:0] seq [4];
      seq[0] = 4'd14; seq[1] = 4'd15; seq[2] = 4'd0; seq[3] = 4'd1;

      // one-shot 3..6, config noise while running is ignored
      add(1, 0, 0, 3, 6, 0, 0, 3, 1, 0, 0);
      add(0, 0, 0, 9, 9, 5, 1, 4, 1, 0, 0);
      add(0, 0, 0, 9, 9, 5, 1, 5, 1, 0, 0);
      add(0, 0, 0, 9, 9, 5, 1, 6, 1, 0, 0);
      add(0, 0, 0, 9, 9, 5, 1, 6, 0, 1, 1);
      add(0, 0, 0, 9, 9, 5, 1, 6, 0, 0, 1);
      add(0, 0, 1, 9, 9, 5, 1, 6, 0, 0, 1);
      // restart from DONE with new config
      add(1, 0, 0, 0, 2, 0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 1);
      add(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1);
      // auto-reload 14..1 wrapping, each value held 3 cycles
      add(1, 0, 0, 14, 1, 2, 1, 14, 1, 0, 0);
      for (int k = 1; k <= 24; k++) begin
         add(0, 0, 0, 0, 0, 0, 0, seq[(k / 3) % 4], 1,
             (k % 12) == 0, 0);
      end
      // start/stop collision at count 5
      add(1, 0, 0, 2, 12, 0, 1, 2, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 4, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0);
      add(1, 1, 0, 9, 9, 0, 0, 5, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 5, 0, 0, 0);
      add(1, 0, 0, 7, 12, 0, 1, 7, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 8, 1, 0, 0);

      res = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (2) tick();
      chk_all("reset", 0, 0, 0, 0);
      res = 1'b1;
      tick();
      chk_all("post_reset_idle", 0, 0, 0, 0);

      foreach (vq[i]) begin
         drive(vq[i].st, vq[i].sp, vq[i].pa, vq[i].lv,
               vq[i].lim, vq[i].pr, vq[i].ar);
         tick();
         chk_all($sformatf("vec%0d", i), int'(vq[i].ec),
                 int'(vq[i].eb), int'(vq[i].et), int'(vq[i].ed));
      end

      // pause mid-prescale: two of four cycles already spent
      drive(1, 0, 0, 0, 15, 3, 0);
      tick();
      chk_all("pause_start", 0, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (2) tick();
      chk_all("pause_pre", 0, 1, 0, 0);
      pause = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk_all($sformatf("pause_hold%0d", k), 0, 1, 0, 0);
      end
      pause = 1'b0;
      tick();
      chk_all("pause_rel0", 0, 1, 0, 0);
      tick();
      chk_all("pause_rel1", 1, 1, 0, 0);
      tick();
      stop = 1'b1;
      tick();
      chk_all("pause_stop", 1, 0, 0, 0);
      stop = 1'b0;

      // asynchronous reset in the middle of a run at count 9
      drive(1, 0, 0, 9, 15, 3, 1);
      tick();
      chk_all("rst_run", 9, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      #2;
      res = 1'b0;
      #1;
      chk_all("rst_async", 0, 0, 0, 0);
      repeat (3) tick();
      chk_all("rst_held", 0, 0, 0, 0);
      res = 1'b1;
      repeat (2) tick();
      chk_all("rst_released", 0, 0, 0, 0);
      drive(1, 0, 0, 4, 5, 0, 0);
      tick();
      chk_all("rst_restart0", 4, 1, 0, 0);
      start = 1'b0;
      tick();
      chk_all("rst_restart1", 5, 1, 0, 0);
      tick();
      chk_all("rst_restart2", 5, 0, 1, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
